// File: rtl/pong_ball_if.sv
// Bundles the game-side signals of the pong ball engine: tick/start/paddle inputs
// and the ball position, scores, point pulse and debug state outputs.
interface pong_ball_if;
  logic        tick;
  logic        start;
  logic [9:0]  paddle1Y;
  logic [9:0]  paddle2Y;
  logic [10:0] ballX;
  logic [9:0]  ballY;
  logic [3:0]  score1;
  logic [3:0]  score2;
  logic        point;
  logic [2:0]  state;

  modport master (
    output tick, start, paddle1Y, paddle2Y,
    input  ballX, ballY, score1, score2, point, state
  );

  modport slave (
    input  tick, start, paddle1Y, paddle2Y,
    output ballX, ballY, score1, score2, point, state
  );
endinterface

// File: rtl/pong_ball.sv
// Ball-physics engine: one move per accepted tick, walked through wall, paddle
// and goal stages before the new position is committed to the outputs.
module pong_ball #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BALL        = 10,
  parameter int STEP        = 2,
  parameter int P1X         = 20,
  parameter int P2X         = 620,
  parameter int PW          = 10,
  parameter int PH          = 50,
  parameter int SERVE_TICKS = 60,
  parameter int MAX_SCORE   = 9
) (
  input  logic       clk,
  input  logic       reset,
  pong_ball_if.slave bus
);

  localparam int SERVE_W = $clog2(SERVE_TICKS + 1);
  localparam logic [10:0] CENTRE_X = 11'((SCREEN_W - BALL) / 2);
  localparam logic [9:0]  CENTRE_Y = 10'((SCREEN_H - BALL) / 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PLAY   = 3'd1,
    S_WALL   = 3'd2,
    S_PADDLE = 3'd3,
    S_GOAL   = 3'd4,
    S_SERVE  = 3'd5,
    S_OVER   = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [10:0]          ball_x_q, ball_x_d;
  logic [9:0]           ball_y_q, ball_y_d;
  logic [10:0]          nx_q, nx_d;
  logic [9:0]           ny_q, ny_d;
  logic [9:0]           p1_q, p1_d;
  logic [9:0]           p2_q, p2_d;
  logic                 dir_x_q, dir_x_d;
  logic                 dir_y_q, dir_y_d;
  logic [3:0]           score1_q, score1_d;
  logic [3:0]           score2_q, score2_d;
  logic                 point_q, point_d;
  logic [SERVE_W-1:0]   serve_cnt_q, serve_cnt_d;

  // Vertical and paddle comparisons run 11 bits wide so bottom edges never wrap.
  logic [10:0] ny_ext;
  logic [10:0] p1_top, p1_bot, p2_top, p2_bot;
  logic        left_hit, right_hit, goal_p1, goal_p2;

  assign ny_ext = {1'b0, ny_q};
  assign p1_top = {1'b0, p1_q};
  assign p1_bot = {1'b0, p1_q} + 11'(PH);
  assign p2_top = {1'b0, p2_q};
  assign p2_bot = {1'b0, p2_q} + 11'(PH);

  assign left_hit  = !dir_x_q
                   && (nx_q <= 11'(P1X + PW))
                   && (nx_q + 11'(BALL) > 11'(P1X))
                   && (ny_ext + 11'(BALL) > p1_top)
                   && (ny_ext < p1_bot);
  assign right_hit = dir_x_q
                   && (nx_q + 11'(BALL) >= 11'(P2X))
                   && (nx_q < 11'(P2X + PW))
                   && (ny_ext + 11'(BALL) > p2_top)
                   && (ny_ext < p2_bot);
  assign goal_p2 = !dir_x_q && (nx_q < 11'(STEP));
  assign goal_p1 = (nx_q + 11'(BALL) >= 11'(SCREEN_W));

  always_comb begin
    state_d     = state_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    nx_d        = nx_q;
    ny_d        = ny_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    point_d     = 1'b0;
    serve_cnt_d = serve_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_PLAY;
      end

      // Horizontal move happens here; the vertical move is left to WALL so the
      // top-wall clamp can be applied before any subtraction.
      S_PLAY: begin
        if (bus.tick) begin
          p1_d = bus.paddle1Y;
          p2_d = bus.paddle2Y;
          ny_d = ball_y_q;
          if (dir_x_q)                   nx_d = ball_x_q + 11'(STEP);
          else if (ball_x_q < 11'(STEP)) nx_d = '0;
          else                           nx_d = ball_x_q - 11'(STEP);
          state_d = S_WALL;
        end
      end

      S_WALL: begin
        if (!dir_y_q) begin
          if (ny_q <= 10'(STEP)) begin
            ny_d    = '0;
            dir_y_d = 1'b1;
          end else begin
            ny_d = ny_q - 10'(STEP);
          end
        end else if (ny_ext + 11'(BALL) + 11'(STEP) >= 11'(SCREEN_H)) begin
          ny_d    = 10'(SCREEN_H - BALL);
          dir_y_d = 1'b0;
        end else begin
          ny_d = ny_q + 10'(STEP);
        end
        state_d = S_PADDLE;
      end

      S_PADDLE: begin
        if (left_hit) begin
          nx_d    = 11'(P1X + PW);
          dir_x_d = 1'b1;
        end else if (right_hit) begin
          nx_d    = 11'(P2X - BALL);
          dir_x_d = 1'b0;
        end
        state_d = S_GOAL;
      end

      // The serve direction heads toward whoever conceded the point.
      S_GOAL: begin
        if (goal_p2 || goal_p1) begin
          point_d     = 1'b1;
          ball_x_d    = CENTRE_X;
          ball_y_d    = CENTRE_Y;
          serve_cnt_d = '0;
          state_d     = S_SERVE;
          if (goal_p2) begin
            score2_d = score2_q + 4'd1;
            dir_x_d  = 1'b0;
            if (score2_q + 4'd1 == 4'(MAX_SCORE)) state_d = S_OVER;
          end else begin
            score1_d = score1_q + 4'd1;
            dir_x_d  = 1'b1;
            if (score1_q + 4'd1 == 4'(MAX_SCORE)) state_d = S_OVER;
          end
        end else begin
          ball_x_d = nx_q;
          ball_y_d = ny_q;
          state_d  = S_PLAY;
        end
      end

      S_SERVE: begin
        if (bus.tick) begin
          if (serve_cnt_q == SERVE_W'(SERVE_TICKS - 1)) begin
            serve_cnt_d = '0;
            state_d     = S_PLAY;
          end else begin
            serve_cnt_d = serve_cnt_q + 1'b1;
          end
        end
      end

      S_OVER: begin
        if (bus.start) begin
          score1_d = '0;
          score2_d = '0;
          dir_x_d  = 1'b1;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ball_x_q    <= CENTRE_X;
      ball_y_q    <= CENTRE_Y;
      nx_q        <= CENTRE_X;
      ny_q        <= CENTRE_Y;
      p1_q        <= '0;
      p2_q        <= '0;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      score1_q    <= '0;
      score2_q    <= '0;
      point_q     <= 1'b0;
      serve_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      nx_q        <= nx_d;
      ny_q        <= ny_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      point_q     <= point_d;
      serve_cnt_q <= serve_cnt_d;
    end
  end

  assign bus.ballX  = ball_x_q;
  assign bus.ballY  = ball_y_q;
  assign bus.score1 = score1_q;
  assign bus.score2 = score2_q;
  assign bus.point  = point_q;
  assign bus.state  = state_q;

endmodule

// File: tb/tb_pong_ball.sv
// Self-checking bench for pong_ball: fixed vector table, directed game sequences
// and randomized play compared against a tick-level reference model.
module tb_pong_ball;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int BALL        = 10;
  localparam int STEP        = 2;
  localparam int P1X         = 20;
  localparam int P2X         = 620;
  localparam int PW          = 10;
  localparam int PH          = 50;
  localparam int SERVE_TICKS = 60;
  localparam int MAX_SCORE   = 9;

  localparam int M_IDLE  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_SERVE = 5;
  localparam int M_OVER  = 6;

  localparam int CX = (SCREEN_W - BALL) / 2;
  localparam int CY = (SCREEN_H - BALL) / 2;

  logic clk;
  logic reset;
  pong_ball_if bus();

  pong_ball #(
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .BALL(BALL), .STEP(STEP),
    .P1X(P1X), .P2X(P2X), .PW(PW), .PH(PH),
    .SERVE_TICKS(SERVE_TICKS), .MAX_SCORE(MAX_SCORE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecCount;
  int missCount;

  // Reference model of the game at whole-tick granularity.
  int mX, mY, mDx, mDy, mS1, mS2, mMode, mServe;
  bit mPoint;

  typedef struct {
    int p1;
    int p2;
    bit dbl;
    int expX;
    int expY;
    int expState;
  } vec_t;

  vec_t tv[6];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic boundExpired(input string name);
    vecCount++;
    missCount++;
    $display("[TB] FAIL %s: bound expired at %0t", name, $time);
  endtask

  task automatic modelReset();
    mX = CX; mY = CY; mDx = 1; mDy = 1;
    mS1 = 0; mS2 = 0; mMode = M_IDLE; mServe = 0; mPoint = 0;
  endtask

  task automatic modelStart();
    if (mMode == M_IDLE) mMode = M_PLAY;
    else if (mMode == M_OVER) begin
      mS1 = 0; mS2 = 0; mDx = 1; mMode = M_IDLE;
    end
  endtask

  task automatic modelTick(input int p1, input int p2);
    int x, y;
    bit goal;
    mPoint = 0;
    goal = 0;
    if (mMode == M_SERVE) begin
      mServe++;
      if (mServe == SERVE_TICKS) begin
        mServe = 0;
        mMode = M_PLAY;
      end
    end else if (mMode == M_PLAY) begin
      x = mX + mDx * STEP;
      if (x < 0) x = 0;
      if (mDy < 0) begin
        if (mY - STEP <= 0) begin y = 0; mDy = 1; end
        else y = mY - STEP;
      end else begin
        if (mY + STEP >= SCREEN_H - BALL) begin y = SCREEN_H - BALL; mDy = -1; end
        else y = mY + STEP;
      end
      if (mDx < 0 && x <= P1X + PW && x + BALL > P1X && y + BALL > p1 && y < p1 + PH) begin
        x = P1X + PW; mDx = 1;
      end else if (mDx > 0 && x + BALL >= P2X && x < P2X + PW && y + BALL > p2 && y < p2 + PH) begin
        x = P2X - BALL; mDx = -1;
      end
      if (mDx < 0 && x < STEP) begin
        mS2++; mDx = -1; goal = 1;
      end else if (x + BALL >= SCREEN_W) begin
        mS1++; mDx = 1; goal = 1;
      end
      if (goal) begin
        mPoint = 1; mX = CX; mY = CY; mServe = 0;
        mMode = (mS1 == MAX_SCORE || mS2 == MAX_SCORE) ? M_OVER : M_SERVE;
      end else begin
        mX = x; mY = y;
      end
    end
  endtask

  function automatic int trackP(input int y);
    return (y >= 20) ? y - 20 : 0;
  endfunction

  // Tick sampled at edge E0; returns just after E3, when the result is visible.
  task automatic applyStimulus(input int p1, input int p2, input bit dbl);
    bus.paddle1Y = 10'(p1);
    bus.paddle2Y = 10'(p2);
    @(posedge clk); #1 bus.tick = 1'b1;
    @(posedge clk); #1 bus.tick = dbl;
    @(posedge clk); #1 bus.tick = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    modelTick(p1, p2);
  endtask

  task automatic finishTick();
    @(posedge clk); #1;
    checkOutput("point_drop", bus.point, 0);
  endtask

  task automatic checkModel();
    checkOutput("ballX", bus.ballX, mX);
    checkOutput("ballY", bus.ballY, mY);
    checkOutput("score1", bus.score1, mS1);
    checkOutput("score2", bus.score2, mS2);
    checkOutput("state", bus.state, mMode);
    checkOutput("point", bus.point, mPoint);
    finishTick();
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, "_x"}, bus.ballX, CX);
    checkOutput({name, "_y"}, bus.ballY, CY);
    checkOutput({name, "_s1"}, bus.score1, 0);
    checkOutput({name, "_s2"}, bus.score2, 0);
    checkOutput({name, "_pt"}, bus.point, 0);
    checkOutput({name, "_st"}, bus.state, M_IDLE);
  endtask

  task automatic pressStart();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    modelStart();
    checkOutput("start_state", bus.state, mMode);
    checkOutput("start_s1", bus.score1, mS1);
    checkOutput("start_s2", bus.score2, mS2);
  endtask

  initial begin
    int guard;
    int p1, p2;
    bit dbl;

    vecCount = 0;
    missCount = 0;
    bus.tick = 1'b0;
    bus.start = 1'b0;
    bus.paddle1Y = '0;
    bus.paddle2Y = '0;
    reset = 1'b1;

    tv[0] = '{0,    0,    1'b0, 317, 237, M_PLAY};
    tv[1] = '{500,  900,  1'b0, 319, 239, M_PLAY};
    tv[2] = '{0,    0,    1'b1, 321, 241, M_PLAY};
    tv[3] = '{1023, 1023, 1'b0, 323, 243, M_PLAY};
    tv[4] = '{240,  240,  1'b1, 325, 245, M_PLAY};
    tv[5] = '{7,    613,  1'b0, 327, 247, M_PLAY};

    #2 reset = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1 checkReset("rst");
    reset = 1'b1;

    applyStimulus(100, 100, 1'b0);
    checkModel();
    pressStart();

    for (int i = 0; i < 6; i++) begin
      applyStimulus(tv[i].p1, tv[i].p2, tv[i].dbl);
      checkOutput("tbl_x", bus.ballX, tv[i].expX);
      checkOutput("tbl_y", bus.ballY, tv[i].expY);
      checkOutput("tbl_state", bus.state, tv[i].expState);
      checkOutput("tbl_point", bus.point, 0);
      finishTick();
    end

    // Reset while the move is in the PADDLE stage.
    @(posedge clk); #1 bus.tick = 1'b1;
    @(posedge clk); #1 bus.tick = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    #1 checkReset("midrst");
    modelReset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 checkReset("postrst");

    $display("[TB] playing player 1 to game over");
    pressStart();
    guard = 0;
    while (mMode != M_OVER && guard < 4000) begin
      applyStimulus(1000, 1000, 1'b0);
      checkModel();
      guard++;
    end
    if (mMode != M_OVER) boundExpired("over_timeout");
    checkOutput("over_state", bus.state, M_OVER);
    checkOutput("over_s1", bus.score1, MAX_SCORE);
    applyStimulus(1000, 1000, 1'b0);
    checkModel();
    pressStart();
    checkOutput("restart_state", bus.state, M_IDLE);
    checkOutput("restart_s1", bus.score1, 0);

    $display("[TB] right paddle return, left miss");
    pressStart();
    guard = 0;
    while (mS2 < 1 && guard < 2000) begin
      applyStimulus(1000, trackP(mY), 1'b0);
      checkModel();
      guard++;
    end
    if (mS2 < 1) boundExpired("miss_timeout");
    checkOutput("miss_s2", bus.score2, 1);
    checkOutput("miss_state", bus.state, M_SERVE);
    for (int i = 0; i < SERVE_TICKS; i++) begin
      applyStimulus(1000, 1000, 1'b0);
      checkModel();
    end
    checkOutput("serve_done", bus.state, M_PLAY);

    $display("[TB] randomized play");
    for (int i = 0; i < 400; i++) begin
      p1 = ($urandom_range(0, 1) == 1) ? trackP(mY) : int'($urandom_range(0, 1023));
      p2 = ($urandom_range(0, 1) == 1) ? trackP(mY) : int'($urandom_range(0, 1023));
      dbl = (mMode == M_PLAY) && ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) pressStart();
      applyStimulus(p1, p2, dbl);
      checkModel();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
